// File: rtl/vedic_pkg.sv
// vedic_pkg: shared types and constants for the
// sequential Vedic multiplier slice.
package vedic_pkg;

  localparam int OP_W   = 16;
  localparam int HALF_W = 8;
  localparam int RES_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DRAIN,
    DONE
  } state_t;

  // Left shift applied to each half-word product
  function automatic logic [4:0] pass_shift(
    input logic [1:0] idx
  );
    logic [4:0] s;
    case (idx)
      2'd0:    s = 5'd0;
      2'd1:    s = 5'd8;
      2'd2:    s = 5'd8;
      default: s = 5'd16;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vedic_8bit_multi.sv
// vedic_8bit_multi: combinational 8x8 unsigned
// multiplier built from four 4x4 crosswise terms.
module vedic_8bit_multi (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [7:0]  ll;
  logic [7:0]  hl;
  logic [7:0]  lh;
  logic [7:0]  hh;
  logic [15:0] mid;

  assign ll = {4'b0, a[3:0]} * {4'b0, b[3:0]};
  assign hl = {4'b0, a[7:4]} * {4'b0, b[3:0]};
  assign lh = {4'b0, a[3:0]} * {4'b0, b[7:4]};
  assign hh = {4'b0, a[7:4]} * {4'b0, b[7:4]};

  assign mid = {8'b0, hl} + {8'b0, lh};
  assign p   = {hh, ll} + (mid << 4);

endmodule

// File: rtl/vedic_16bit_seq_mul.sv
// vedic_16bit_seq_mul: 16x16 multiplier that runs four
// passes through one shared 8x8 Vedic core.
module vedic_16bit_seq_mul
  import vedic_pkg::*;
#(
  parameter int MUL_PIPE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  p
);

  state_t state_q;
  state_t state_d;

  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [1:0]          idx_q;
  logic [RES_W-1:0]    acc_q;
  logic [RES_W-1:0]    prod_q;
  logic [RES_W-1:0]    pp_ext;
  logic [HALF_W-1:0]   a_half;
  logic [HALF_W-1:0]   b_half;
  logic [2*HALF_W-1:0] pp;

  // idx bit 0 picks the high byte of a, bit 1 of b
  assign a_half = idx_q[0] ? a_q[OP_W-1:HALF_W]
                           : a_q[HALF_W-1:0];
  assign b_half = idx_q[1] ? b_q[OP_W-1:HALF_W]
                           : b_q[HALF_W-1:0];

  vedic_8bit_multi u_core (
    .a (a_half),
    .b (b_half),
    .p (pp)
  );

  assign pp_ext = {{(RES_W-2*HALF_W){1'b0}}, pp}
                  << pass_shift(idx_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = acc_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: four passes, optional drain, hold result
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_valid) state_d = MUL;
      MUL:   if (idx_q == 2'd3)
               state_d = (MUL_PIPE != 0) ? DRAIN : DONE;
      DRAIN: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, pass index, product reg and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      prod_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q    <= a;
          b_q    <= b;
          idx_q  <= '0;
          acc_q  <= '0;
          prod_q <= '0;
        end
        MUL: begin
          idx_q <= idx_q + 2'd1;
          if (MUL_PIPE != 0) begin
            prod_q <= pp_ext;
            acc_q  <= acc_q + prod_q;
          end else begin
            acc_q  <= acc_q + pp_ext;
          end
        end
        DRAIN: acc_q <= acc_q + prod_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_16bit_seq_mul.sv
// tb_vedic_16bit_seq_mul: directed checks on both
// the combinational and registered-product builds.
module tb_vedic_16bit_seq_mul;

  logic        clk;
  logic        rst_n;
  logic        iv0, ir0, ov0, or0;
  logic [15:0] a0, b0;
  logic [31:0] p0;
  logic        iv1, ir1, ov1, or1;
  logic [15:0] a1, b1;
  logic [31:0] p1;

  int n_chk;
  int n_pass;
  int cyc;

  vedic_16bit_seq_mul #(.MUL_PIPE(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv0),
    .in_ready  (ir0),
    .a         (a0),
    .b         (b0),
    .out_valid (ov0),
    .out_ready (or0),
    .p         (p0)
  );

  vedic_16bit_seq_mul #(.MUL_PIPE(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .a         (a1),
    .b         (b1),
    .out_valid (ov1),
    .out_ready (or1),
    .p         (p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit pipe, input logic v,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       input logic r);
    if (pipe) begin
      iv1 = v; a1 = x; b1 = y; or1 = r;
    end else begin
      iv0 = v; a0 = x; b0 = y; or0 = r;
    end
  endtask

  function automatic logic get_ir(input bit pipe);
    return pipe ? ir1 : ir0;
  endfunction

  function automatic logic get_ov(input bit pipe);
    return pipe ? ov1 : ov0;
  endfunction

  function automatic logic [31:0] get_p(input bit pipe);
    return pipe ? p1 : p0;
  endfunction

  // One full transaction with out_ready high
  task automatic do_op(input bit pipe,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       input logic [31:0] exp,
                       input int lat,
                       input string tag);
    int n;
    check({tag, "_rdy"}, 32'(get_ir(pipe)), 32'd1);
    drive(pipe, 1'b1, x, y, 1'b1);
    step();
    drive(pipe, 1'b0, 16'h0, 16'h0, 1'b1);
    n = 0;
    do begin
      step();
      n++;
    end while (!get_ov(pipe) && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_p"}, get_p(pipe), exp);
    step();
    check({tag, "_ov1cyc"}, 32'(get_ov(pipe)), 32'd0);
  endtask

  // Back-to-back issue with random operands
  task automatic burst(input bit pipe, input int ival,
                       input int lat, input string tag);
    int n;
    int t;
    int t_prev;
    logic [15:0] x;
    logic [15:0] y;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      drive(pipe, 1'b1, x, y, 1'b1);
      n = 0;
      while (!get_ir(pipe) && n < 20) begin
        step();
        n++;
      end
      t = cyc;
      step();
      if (k > 0)
        check({tag, "_ival"}, 32'(t - t_prev), 32'(ival));
      t_prev = t;
      n = 0;
      while (!get_ov(pipe) && n < 20) begin
        step();
        n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(lat));
      check({tag, "_p"}, get_p(pipe), 32'(x) * 32'(y));
    end
    drive(pipe, 1'b0, 16'h0, 16'h0, 1'b1);
    step();
  endtask

  initial begin
    int n;
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    #2;
    check("rst_ir0", 32'(ir0), 32'd1);
    check("rst_ov0", 32'(ov0), 32'd0);
    check("rst_p0", p0, 32'h0);
    check("rst_ir1", 32'(ir1), 32'd1);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_p1", p1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    do_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4, "max");
    do_op(1'b0, 16'h1234, 16'h5678, 32'h06260060, 4, "mix");
    do_op(1'b0, 16'h8000, 16'h0002, 32'h00010000, 4, "msb");
    do_op(1'b0, 16'h0000, 16'hABCD, 32'h00000000, 4, "zero");

    // Back-pressure with a new request waiting
    drive(1'b0, 1'b1, 16'd7, 16'd9, 1'b0);
    step();
    drive(1'b0, 1'b0, 16'd7, 16'd9, 1'b0);
    n = 0;
    while (!ov0 && n < 20) begin
      step();
      n++;
    end
    drive(1'b0, 1'b1, 16'd3, 16'd5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_p", p0, 32'd63);
      check("bp_ov", 32'(ov0), 32'd1);
      check("bp_ir", 32'(ir0), 32'd0);
    end
    drive(1'b0, 1'b1, 16'd3, 16'd5, 1'b1);
    step();
    check("rel_ir", 32'(ir0), 32'd1);
    check("rel_ov", 32'(ov0), 32'd0);
    check("rel_hold", p0, 32'd63);
    step();
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    n = 0;
    do begin
      step();
      n++;
    end while (!ov0 && n < 20);
    check("rel_lat", 32'(n), 32'd4);
    check("rel_p", p0, 32'd15);
    step();

    // Async reset during pass idx2
    drive(1'b0, 1'b1, 16'h1234, 16'h5678, 1'b1);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(ov0), 32'd0);
    check("mid_rst_ir", 32'(ir0), 32'd1);
    check("mid_rst_p", p0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_op(1'b0, 16'h0100, 16'h0100, 32'h00010000, 4, "post_rst");

    do_op(1'b1, 16'h00FF, 16'hFF00, 32'h00FE0100, 5, "pipe");
    do_op(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5, "pipe_max");

    burst(1'b0, 6, 4, "b2b0");
    burst(1'b1, 7, 5, "b2b1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vedic_16bit_seq_mul.md
# vedic_16bit_seq_mul

Multi-cycle 16x16 unsigned multiplier that reuses a single `vedic_8bit_multi` instance over four partial-product passes. It sits between a requester and the shared 8x8 Vedic datapath. It accepts operands over a valid/ready handshake, sequences the four half-word products, and accumulates them into a 32-bit result presented over a second valid/ready handshake.

## Interface
Parameters:
- `MUL_PIPE`, default 0: 0 = combinational 8x8 product used the same cycle; 1 = product registered before accumulation, which adds one cycle of latency.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands on `a`/`b` are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  16  multiplicand, unsigned.
- `b`  in  16  multiplier, unsigned.
- `out_valid`  out  1  `p` holds a completed product.
- `out_ready`  in  1  consumer accepts `p`.
- `p`  out  32  product a*b.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL: 4 passes, indexed by 2-bit `idx`.
  - DRAIN: only when `MUL_PIPE`=1; one cycle to accumulate the last registered product.
  - DONE: `out_valid`=1.
- IDLE -> MUL on `in_valid && in_ready`:
  - latch `a` and `b`, clear the 32-bit accumulator, set `idx`=0.
- Pass order (product << shift):
  - idx0: a[7:0]*b[7:0] << 0
  - idx1: a[15:8]*b[7:0] << 8
  - idx2: a[7:0]*b[15:8] << 8
  - idx3: a[15:8]*b[15:8] << 16
- Width rules:
  - Each 8x8 product is 16 bits, zero-extended to 32 before the shift.
  - The accumulator is 32 bits; the final sum never exceeds 32'hFFFE0001, so no overflow logic is needed.
- MUL, `MUL_PIPE`=0:
  - Each cycle, acc += shifted product of the current `idx`, then `idx` increments.
  - After idx3: MUL -> DONE.
- MUL, `MUL_PIPE`=1:
  - The product register captures pass `idx`; the accumulator adds the previously registered pass.
  - After idx3: MUL -> DRAIN -> DONE.
- DONE:
  - `p` = accumulator, held stable with `out_valid` high until `out_valid && out_ready`; then DONE -> IDLE.
  - `in_valid` is ignored outside IDLE; latched operands are never overwritten mid-operation.
- `p` keeps the last result after return to IDLE. Only `out_valid` qualifies it.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `p`=0, accumulator=0, `idx`=0, product register=0.
- Reset mid-operation: takes effect immediately (asynchronous); the in-flight operation is discarded with no output.
- Latency, clock edges from the accept edge to `out_valid` high:
  - 4 when `MUL_PIPE`=0.
  - 5 when `MUL_PIPE`=1.
- Minimum issue interval: 6 cycles (`MUL_PIPE`=0) or 7 cycles (`MUL_PIPE`=1), with `out_ready` held high.
- The output handshake edge returns the block to IDLE; the next accept happens no earlier than the following edge.
- `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from inputs.
- Back-pressure: while `out_ready`=0 in DONE, `p` and `out_valid` stay constant for an unbounded time.

## Structure
- Shared package `vedic_pkg` holds:
  - state enum (IDLE, MUL, DRAIN, DONE);
  - constants: operand width 16, half width 8, result width 32;
  - the pass-to-shift mapping (0, 8, 8, 16).
- One sub-module: an instance of the existing `vedic_8bit_multi`, fed by a 2:1 half-select mux on each operand.
- The FSM, accumulator, and optional product register live in the top-level module.

## Test plan
- a=16'hFFFF, b=16'hFFFF, `MUL_PIPE`=0, `out_ready`=1 -> `p`=32'hFFFE0001, with `out_valid` high exactly 4 edges after accept and for 1 cycle.
- a=16'h1234, b=16'h5678 -> `p`=32'h06260060; a=16'h8000, b=16'h0002 -> `p`=32'h00010000; a=0, b=16'hABCD -> `p`=0.
- Result held with `out_ready`=0 for 10 cycles, and a new `in_valid` with a=3, b=5 presented meanwhile:
  - `p` and `out_valid` stay constant, `in_ready`=0;
  - after release, the 3*5 operation is accepted only once back in IDLE and returns `p`=15.
- `rst_n` pulsed low during pass idx2 -> `out_valid`=0, `in_ready`=1, `p`=0 immediately; the next operation 16'h0100*16'h0100 returns 32'h00010000.
- `MUL_PIPE`=1, a=16'h00FF, b=16'hFF00 -> `p`=32'h00FE0100 after 5 edges.
- Back-to-back with `in_valid` and `out_ready` held high and random operands -> a result every 6 cycles (7 with `MUL_PIPE`=1), matching the golden a*b.
